// File: rtl/ground_pkg.sv
// ground_pkg: shared state encoding, ground geometry, background colour and wrap helper.
package ground_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DEAD = 2'd3} state_t;
    localparam int ADDR_W = 18;
    localparam logic [10:0] GND_X0 = 11'd350;
    localparam logic [10:0] GND_Y0 = 11'd750;
    localparam logic [9:0] GND_W = 10'd740;
    localparam logic [7:0] GND_H = 8'd150;
    localparam logic [10:0] GND_X1 = GND_X0 + {1'b0, GND_W};
    localparam logic [10:0] GND_Y1 = GND_Y0 + {3'd0, GND_H};
    localparam logic [3:0] BG_R = 4'h7;
    localparam logic [3:0] BG_G = 4'hC;
    localparam logic [3:0] BG_B = 4'hC;
    localparam logic [11:0] BG_RGB = {BG_R, BG_G, BG_B};

    // (a + b) mod GND_W, valid while both operands are below GND_W
    function automatic logic [9:0] wrap_add(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, GND_W}) ? 10'(s - {1'b0, GND_W}) : s[9:0];
    endfunction
endpackage

// File: rtl/ground_addr_gen.sv
// ground_addr_gen: stage-1 region test, scrolled column wrap and row-major ROM address.
module ground_addr_gen
    import ground_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       pos_x,
    input  logic [10:0]       pos_y,
    input  logic [9:0]        scroll_off,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              valid
);
    logic in_region;
    logic [9:0] dx;
    logic [9:0] col;
    logic [7:0] dy;
    logic [ADDR_W-1:0] row_base;

    always_comb begin
        in_region = pos_x >= GND_X0 && pos_x < GND_X1 && pos_y >= GND_Y0 && pos_y < GND_Y1;
        dx = 10'(pos_x - GND_X0);
        dy = 8'(pos_y - GND_Y0);
        col = wrap_add(dx, scroll_off);
        row_base = {10'd0, dy} * {8'd0, GND_W};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr <= '0;
            valid <= 1'b0;
        end else begin
            rom_addr <= in_region ? row_base + {8'd0, col} : '0;
            valid <= in_region;
        end
    end
endmodule

// File: rtl/ground_scroll_ctrl.sv
// ground_scroll_ctrl: game FSM, per-frame ground scroll and 3-stage ROM colour pipeline.
// Define GROUND_SPEEDUP_EN to raise the scroll step every 512 running frames up to MAX_SPEED.
module ground_scroll_ctrl
    import ground_pkg::*;
#(
    parameter int SPEED = 2,
    parameter int MAX_SPEED = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] pos_x,
    input  logic [10:0] pos_y,
    input  logic        frame_start,
    input  logic        game_start,
    input  logic        game_over,
    input  logic        pause,
    output logic [17:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [3:0]  groundr,
    output logic [3:0]  groundg,
    output logic [3:0]  groundb,
    output logic        isground,
    output logic [9:0]  scroll_off,
    output logic [1:0]  state
);
    state_t cur, nxt;
    logic running, start_run, v1, v2;
    logic [9:0] step;

    always_ff @(posedge clk) begin
        if (!rst_n) cur <= IDLE;
        else cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    nxt = (game_start && !game_over) ? RUN : IDLE;
            RUN:     nxt = game_over ? DEAD : pause ? PAUSED : RUN;
            PAUSED:  nxt = game_over ? DEAD : !pause ? RUN : PAUSED;
            DEAD:    nxt = (game_start && !game_over) ? RUN : DEAD;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        state = cur;
        running = cur == RUN;
        start_run = (cur == IDLE || cur == DEAD) && nxt == RUN;
    end

    // restart clears the offset on the same edge that enters RUN
    always_ff @(posedge clk) begin
        if (!rst_n || start_run) scroll_off <= '0;
        else if (frame_start && running) scroll_off <= wrap_add(scroll_off, step);
    end

`ifdef GROUND_SPEEDUP_EN
    logic [8:0] frame_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n || start_run) begin
            frame_cnt <= '0;
            step <= 10'(SPEED);
        end else if (frame_start && running) begin
            frame_cnt <= frame_cnt + 9'd1;
            if (&frame_cnt && step < 10'(MAX_SPEED)) step <= step + 10'd1;
        end
    end
`else
    assign step = 10'(SPEED);
`endif

    ground_addr_gen u_addr (
        .clk        (clk),
        .rst_n      (rst_n),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .scroll_off (scroll_off),
        .rom_addr   (rom_addr),
        .valid      (v1)
    );

    // rom_data lines up with v2, one edge after the address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            isground <= 1'b0;
            {groundr, groundg, groundb} <= BG_RGB;
        end else begin
            v2 <= v1;
            isground <= v2;
            {groundr, groundg, groundb} <= v2 ? rom_data : BG_RGB;
        end
    end
endmodule

// File: tb/tb_ground_scroll_ctrl.sv
// tb_ground_scroll_ctrl: randomized self-checking bench with an arithmetic reference model.
module tb_ground_scroll_ctrl;
    localparam int SPEED = 2;
    localparam int MAX_SPEED = 8;
    localparam int BG = 'h7CC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [10:0] pos_x = '0;
    logic [10:0] pos_y = '0;
    logic frame_start = 1'b0;
    logic game_start = 1'b0;
    logic game_over = 1'b0;
    logic pause = 1'b0;
    logic [17:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic [3:0] groundr, groundg, groundb;
    logic isground;
    logic [9:0] scroll_off;
    logic [1:0] state;
    logic [11:0] rgb;

    int checks = 0;
    int failures = 0;
    int m_state, m_off, m_step, m_cnt;

    assign rgb = {groundr, groundg, groundb};

    ground_scroll_ctrl #(.SPEED(SPEED), .MAX_SPEED(MAX_SPEED)) dut (
        .clk(clk), .rst_n(rst_n), .pos_x(pos_x), .pos_y(pos_y),
        .frame_start(frame_start), .game_start(game_start), .game_over(game_over), .pause(pause),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .groundr(groundr), .groundg(groundg), .groundb(groundb),
        .isground(isground), .scroll_off(scroll_off), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_fn(input logic [17:0] a);
        return a[11:0] ^ {a[17:12], a[17:12]} ^ 12'h5A3;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    function automatic int in_fn(input int x, input int y);
        return (x >= 350 && x < 1090 && y >= 750 && y < 900) ? 1 : 0;
    endfunction

    function automatic int addr_fn(input int x, input int y, input int off);
        return in_fn(x, y) ? (y - 750) * 740 + (x - 350 + off) % 740 : 0;
    endfunction

    function automatic int rgb_fn(input int x, input int y, input int off);
        return in_fn(x, y) ? int'(rom_fn(18'(addr_fn(x, y, off)))) : BG;
    endfunction

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic tick();
        int ns;
        ns = m_state;
        if ((m_state == 1 || m_state == 2) && game_over) ns = 3;
        else if ((m_state == 0 || m_state == 3) && game_start && !game_over) ns = 1;
        else if (m_state == 1 && pause) ns = 2;
        else if (m_state == 2 && !pause) ns = 1;
        if (!rst_n) begin
            ns = 0; m_off = 0; m_step = SPEED; m_cnt = 0;
        end else if ((m_state == 0 || m_state == 3) && ns == 1) begin
            m_off = 0; m_step = SPEED; m_cnt = 0;
        end else if (frame_start && m_state == 1) begin
            m_off = (m_off + m_step) % 740;
`ifdef GROUND_SPEEDUP_EN
            m_cnt = m_cnt + 1;
            if (m_cnt == 512) begin
                m_cnt = 0;
                if (m_step < MAX_SPEED) m_step = m_step + 1;
            end
`endif
        end
        m_state = ns;
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic restart();
        game_over = 1'b1; tick();
        game_over = 1'b0; game_start = 1'b1; tick();
        game_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pos_x = 11'd700; pos_y = 11'd800;
        tick(); tick();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (scroll_off !== 10'd0) begin failures++; $display("FAIL reset_off got=%0d exp=0", scroll_off); end
        checks++; if (rom_addr !== 18'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
        checks++; if (isground !== 1'b0) begin failures++; $display("FAIL reset_isground got=%b exp=0", isground); end
        checks++; if (rgb !== 12'h7CC) begin failures++; $display("FAIL reset_rgb got=%h exp=7cc", rgb); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_pixel();
        pos_x = 11'd350; pos_y = 11'd750;
        tick();
        checks++; if (rom_addr !== 18'(addr_fn(350, 750, m_off))) begin failures++; $display("FAIL idle_addr got=%0d exp=%0d", rom_addr, addr_fn(350, 750, m_off)); end
        tick(); tick();
        checks++; if (isground !== 1'b1) begin failures++; $display("FAIL idle_isground got=%b exp=1", isground); end
        checks++; if (rgb !== 12'(rgb_fn(350, 750, m_off))) begin failures++; $display("FAIL idle_rgb got=%h exp=%h", rgb, rgb_fn(350, 750, m_off)); end
    endtask

    task automatic test_scroll();
        game_start = 1'b1; tick(); game_start = 1'b0;
        checks++; if (state !== 2'(m_state)) begin failures++; $display("FAIL start_state got=%0d exp=%0d", state, m_state); end
        repeat (10) frame();
        checks++; if (scroll_off !== 10'(m_off)) begin failures++; $display("FAIL scroll10 got=%0d exp=%0d", scroll_off, m_off); end
        pos_x = 11'd350; pos_y = 11'd751;
        tick();
        checks++; if (rom_addr !== 18'(addr_fn(350, 751, m_off))) begin failures++; $display("FAIL scroll_addr got=%0d exp=%0d", rom_addr, addr_fn(350, 751, m_off)); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 400 && m_off != 738; k++) frame();
        checks++; if (scroll_off !== 10'(m_off)) begin failures++; $display("FAIL pre_wrap got=%0d exp=%0d", scroll_off, m_off); end
        frame();
        checks++; if (scroll_off !== 10'(m_off)) begin failures++; $display("FAIL wrap got=%0d exp=%0d", scroll_off, m_off); end
        for (int k = 0; k < 400 && m_off != 730; k++) frame();
        pos_x = 11'd1089; pos_y = 11'd750;
        tick();
        checks++; if (rom_addr !== 18'(addr_fn(1089, 750, m_off))) begin failures++; $display("FAIL wrap_addr got=%0d exp=%0d", rom_addr, addr_fn(1089, 750, m_off)); end
    endtask

    task automatic test_pause();
        pause = 1'b1; tick();
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL pause_state got=%0d exp=2", state); end
        repeat (5) frame();
        checks++; if (scroll_off !== 10'(m_off)) begin failures++; $display("FAIL pause_off got=%0d exp=%0d", scroll_off, m_off); end
        game_over = 1'b1; game_start = 1'b1; tick();
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL dead_state got=%0d exp=3", state); end
        game_over = 1'b0; game_start = 1'b0; pause = 1'b0;
        frame();
        checks++; if (scroll_off !== 10'(m_off)) begin failures++; $display("FAIL dead_off got=%0d exp=%0d", scroll_off, m_off); end
        game_start = 1'b1; tick(); game_start = 1'b0;
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL restart_state got=%0d exp=1", state); end
        checks++; if (scroll_off !== 10'd0) begin failures++; $display("FAIL restart_off got=%0d exp=0", scroll_off); end
    endtask

    task automatic test_edges();
        int xs[8] = '{349, 1090, 700, 700, 350, 1089, 350, 1089};
        int ys[8] = '{800, 800, 900, 749, 750, 750, 899, 899};
        for (int i = 0; i < 8; i++) begin
            pos_x = 11'(xs[i]); pos_y = 11'(ys[i]);
            tick();
            checks++; if (rom_addr !== 18'(addr_fn(xs[i], ys[i], m_off))) begin failures++; $display("FAIL edge_addr x=%0d y=%0d got=%0d exp=%0d", xs[i], ys[i], rom_addr, addr_fn(xs[i], ys[i], m_off)); end
            tick(); tick();
            checks++; if (isground !== 1'(in_fn(xs[i], ys[i]))) begin failures++; $display("FAIL edge_in x=%0d y=%0d got=%b exp=%0d", xs[i], ys[i], isground, in_fn(xs[i], ys[i])); end
            checks++; if (rgb !== 12'(rgb_fn(xs[i], ys[i], m_off))) begin failures++; $display("FAIL edge_rgb x=%0d y=%0d got=%h exp=%h", xs[i], ys[i], rgb, rgb_fn(xs[i], ys[i], m_off)); end
        end
    endtask

    task automatic test_random_fsm();
        for (int i = 0; i < 400; i++) begin
            game_over = ($urandom_range(15) == 0);
            game_start = ($urandom_range(7) == 0);
            if ($urandom_range(7) == 0) pause = ~pause;
            frame_start = ($urandom_range(2) == 0);
            tick();
            checks++; if (state !== 2'(m_state)) begin failures++; $display("FAIL rnd_state i=%0d got=%0d exp=%0d", i, state, m_state); end
            checks++; if (scroll_off !== 10'(m_off)) begin failures++; $display("FAIL rnd_off i=%0d got=%0d exp=%0d", i, scroll_off, m_off); end
        end
        game_over = 1'b0; game_start = 1'b0; pause = 1'b0; frame_start = 1'b0;
    endtask

`ifdef GROUND_SPEEDUP_EN
    task automatic test_speedup();
        restart();
        repeat (513) frame();
        checks++; if (scroll_off !== 10'(m_off)) begin failures++; $display("FAIL speedup_off got=%0d exp=%0d", scroll_off, m_off); end
        checks++; if (m_step !== 3) begin failures++; $display("FAIL speedup_step model=%0d exp=3", m_step); end
        repeat (512 * 7) frame();
        checks++; if (scroll_off !== 10'(m_off)) begin failures++; $display("FAIL speedup_sat got=%0d exp=%0d", scroll_off, m_off); end
    endtask
`endif

    task automatic test_pixel_stream();
        int ex[200], ey[200];
        restart();
        repeat ($urandom_range(300)) frame();
        for (int i = 0; i < 200; i++) begin
            ex[i] = ($urandom_range(3) == 0) ? int'($urandom_range(2047)) : 300 + int'($urandom_range(840));
            ey[i] = ($urandom_range(3) == 0) ? int'($urandom_range(2047)) : 700 + int'($urandom_range(250));
            pos_x = 11'(ex[i]); pos_y = 11'(ey[i]);
            tick();
            checks++; if (rom_addr !== 18'(addr_fn(ex[i], ey[i], m_off))) begin failures++; $display("FAIL stream_addr i=%0d got=%0d exp=%0d", i, rom_addr, addr_fn(ex[i], ey[i], m_off)); end
            if (i >= 2) begin
                checks++; if (isground !== 1'(in_fn(ex[i-2], ey[i-2]))) begin failures++; $display("FAIL stream_in i=%0d got=%b exp=%0d", i, isground, in_fn(ex[i-2], ey[i-2])); end
                checks++; if (rgb !== 12'(rgb_fn(ex[i-2], ey[i-2], m_off))) begin failures++; $display("FAIL stream_rgb i=%0d got=%h exp=%h", i, rgb, rgb_fn(ex[i-2], ey[i-2], m_off)); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        pos_x = 11'd500; pos_y = 11'd800;
        tick(); tick(); tick();
        checks++; if (isground !== 1'b1) begin failures++; $display("FAIL pre_rst_in got=%b exp=1", isground); end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (isground !== 1'b0) begin failures++; $display("FAIL rst_mid_in cyc=%0d got=%b exp=0", i, isground); end
            checks++; if (rgb !== 12'h7CC) begin failures++; $display("FAIL rst_mid_rgb cyc=%0d got=%h exp=7cc", i, rgb); end
            tick();
        end
        checks++; if (rgb !== 12'(rgb_fn(500, 800, m_off))) begin failures++; $display("FAIL post_rst_rgb got=%h exp=%h", rgb, rgb_fn(500, 800, m_off)); end
    endtask

    initial begin
        m_state = 0; m_off = 0; m_step = SPEED; m_cnt = 0;
        test_reset();
        test_idle_pixel();
        test_scroll();
        test_wrap();
        test_pause();
        test_edges();
        test_random_fsm();
`ifdef GROUND_SPEEDUP_EN
        test_speedup();
`endif
        test_pixel_stream();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ground_scroll_ctrl.md
Name: ground_scroll_ctrl

Overview:
- Sequences the ground-strip sprite ROM (740x150 px, 12-bit RGB444, 1-cycle synchronous read) for the VGA pixel pipeline.
- Runs a game-state FSM that advances a horizontal scroll offset once per frame, then maps each pixel coordinate to a wrapped ROM address.
- Returns pipeline-aligned ground colour and an in-region flag to the pixel mixer.
- Sits between the VGA timing generator / game-state logic and the ground ROM instance.

Parameters:
- GND_X0, 350, left edge of ground region (inclusive).
- GND_Y0, 750, top edge of ground region (inclusive).
- GND_W, 740, region and sprite width in px.
- GND_H, 150, region and sprite height in px.
- SPEED, 2, scroll step in px per frame; legal range 1..GND_W-1.
- MAX_SPEED, 8, speed ceiling, used only with the optional feature.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous reset, active-low.
- pos_x  in  11  current pixel column.
- pos_y  in  11  current pixel row.
- frame_start  in  1  one-cycle pulse at start of each frame.
- game_start  in  1  level; start or restart request.
- game_over  in  1  level; player died.
- pause  in  1  level; freeze scrolling.
- rom_addr  out  18  ground ROM address.
- rom_data  in  12  ground ROM data, valid 1 cycle after rom_addr.
- groundr  out  4  ground red.
- groundg  out  4  ground green.
- groundb  out  4  ground blue.
- isground  out  1  pixel lies in ground region.
- scroll_off  out  10  current offset, 0..GND_W-1.
- state  out  2  FSM state encoding.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low (rst_n); all state is cleared on a clk edge with rst_n=0.
- Reset values:
  - state=IDLE(0), scroll_off=0, rom_addr=0.
  - isground=0 and all pipeline valid flags cleared.
  - groundr/g/b=7/C/C (sky background).
- FSM states:
  - IDLE=0: offset held at 0.
  - RUN=1: offset advances.
  - PAUSED=2: offset frozen.
  - DEAD=3: offset frozen.
- FSM transitions, evaluated every cycle:
  - game_over in RUN or PAUSED -> DEAD. game_over has priority over game_start and pause.
  - IDLE or DEAD with game_start=1 and game_over=0 -> RUN, with scroll_off cleared to 0 on the same edge.
  - RUN with pause=1 -> PAUSED.
  - PAUSED with pause=0 -> RUN.
- Scroll update: only on an edge where frame_start=1 and state is RUN (state sampled before the same-edge transition).
  - s = scroll_off + SPEED.
  - scroll_off <= (s >= GND_W) ? s - GND_W : s.
  - A frame_start pulse while in PAUSED, DEAD or IDLE leaves the offset unchanged.
- Pipeline: 3 cycles from pos_x/pos_y to colour outputs.
  - Stage 1 (edge 1):
    - in = (GND_X0 <= pos_x < GND_X0+GND_W) && (GND_Y0 <= pos_y < GND_Y0+GND_H).
    - col = pos_x - GND_X0 + scroll_off, minus GND_W if >= GND_W.
    - rom_addr <= in ? (pos_y - GND_Y0)*GND_W + col : 0.
    - Register in as v1.
    - Multiply is built from shifts/adds or a single DSP; the result must fit 18 bits.
  - Stage 2 (edge 2): ROM presents rom_data; v2 <= v1.
  - Stage 3 (edge 3):
    - If v2: isground <= 1 and {groundr,g,b} <= rom_data.
    - Else: isground <= 0 and colours <= 7/C/C.
- The offset used by stage 1 is the value registered at that edge; a mid-frame offset change never occurs, because frame_start precedes visible pixels.
- Region boundaries: x=349 and x=1090 are outside; x=350 and x=1089 are inside. y=749 and y=900 are outside; y=750 and y=899 are inside.
- Reset mid-frame: pipeline flags clear immediately and outputs return to background on the next edge; no stale ROM data is presented.

Optional Feature:
- Macro: GROUND_SPEEDUP_EN.
- When defined:
  - A 9-bit frame counter increments on each frame_start while in RUN.
  - On wrap, i.e. every 512 RUN frames, the effective step increments by 1, saturating at MAX_SPEED.
  - The step and counter reset to SPEED and 0 on rst_n and on entry to RUN from IDLE or DEAD.
- When undefined: the step is constant SPEED and no counter logic exists.

Decomposition:
- Shared package ground_pkg holds:
  - state enum (IDLE/RUN/PAUSED/DEAD with the encodings above);
  - GND_* geometry constants;
  - background colour constants 7/C/C;
  - ROM address width 18.
- One natural sub-module: ground_addr_gen, which contains stage-1 region test, column wrap and address multiply.
- The FSM, scroll register and output stages stay in the top.

Test Plan:
- Reset, then pos=(350,750) with state IDLE -> rom_addr=0 after 1 cycle; isground=1 and colour=ROM[0] after 3 cycles.
- game_start then 10 frame_start pulses, SPEED=2 -> scroll_off=20. Then pos=(350,751) -> rom_addr=740+20=760.
- Offset 738, one frame_start -> scroll_off=0. Then set offset 730, pos=(1089,750) -> col=739+730-740=729, rom_addr=729.
- pause=1 then 5 frame_start -> offset unchanged and state=PAUSED. Assert game_over and pause together -> DEAD. Then game_start -> RUN with offset 0.
- Region edges: pos_x=349, pos_x=1090 and pos_y=900 -> isground=0 and colour 7/C/C after 3 cycles; pos_y=899, pos_x=1089 -> rom_addr=149*740+739=110999.
- With GROUND_SPEEDUP_EN: 512 RUN frames -> step=3. Saturation check -> step stops at MAX_SPEED=8.
